dct_coef_accum: RTL and testbench

- Sequential 2-D DCT coefficient engine.
- Consumes one NxN pixel block streamed in raster order and produces a single coefficient for a runtime-selected (k1,k2).
- Generalises the fixed per-(k1,k2) combinational cosine tables to any frequency pair selected at start, with streaming handshakes and accumulation.
- Sits between the block buffer and the coefficient store in the fpga/dct pipeline.

---
 rtl/dct_pkg.sv | 53 +++++
 rtl/dct_cos_term.sv | 41 ++++
 rtl/dct_coef_accum.sv | 142 ++++++++++++++
 tb/tb_dct_coef_accum.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/dct_pkg.sv
// dct_pkg: shared constants, types and the 1-D cosine table for the DCT
// coefficient engine.
//
// Contents:
//   N, LOG2N, COS_FRAC  block size and cosine product scaling.
//   COS_Q, PHASE_W      precision of the 1-D cosine table and phase width.
//   state_t             engine states IDLE / ACCUM / DONE.
//   cos_t               signed 32-bit cosine product term.
//   cos_q()             cos(m*pi/(2N)) in Q(COS_Q), built for N = 8.
//
// Optional build macro used by the engine: DCT_SAT_EN (output saturation).
package dct_pkg;

  localparam int N        = 8;
  localparam int LOG2N    = 3;
  localparam int COS_FRAC = 8;
  localparam int COS_Q    = 20;
  localparam int PHASE_W  = LOG2N + 2;

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  typedef logic signed [31:0] cos_t;

  // cos(m*pi/16) for a phase m taken modulo 32 (one full period).
  // The phase is folded into 0..8 using even symmetry and
  // cos(pi - x) = -cos(x). Table values are rounded Q20 and are symmetric in
  // magnitude, so pairs that cancel exactly in real arithmetic also cancel here.
  function automatic cos_t cos_q(input logic [PHASE_W-1:0] m);
    logic [PHASE_W-1:0] r;
    logic               neg;
    cos_t               mag;
    r   = m;
    neg = 1'b0;
    if (r > PHASE_W'(2*N)) r = -r;
    if (r > PHASE_W'(N)) begin
      neg = 1'b1;
      r   = PHASE_W'(2*N) - r;
    end
    case (r[3:0])
      4'd0:    mag = 32'sd1048576;
      4'd1:    mag = 32'sd1028428;
      4'd2:    mag = 32'sd968758;
      4'd3:    mag = 32'sd871859;
      4'd4:    mag = 32'sd741455;
      4'd5:    mag = 32'sd582558;
      4'd6:    mag = 32'sd401273;
      4'd7:    mag = 32'sd204567;
      default: mag = 32'sd0;
    endcase
    return neg ? -mag : mag;
  endfunction

endpackage

// File: rtl/dct_cos_term.sv
// dct_cos_term: combinational 2-D cosine product term
//   trunc_toward_zero(2^FRAC * cos((2n1+1)k1*pi/16) * cos((2n2+1)k2*pi/16)).
//
// Ports:
//   k1, k2  in   frequency indices (vertical, horizontal).
//   n1, n2  in   pixel row / column.
//   term    out  signed 32-bit product term.
module dct_cos_term
  import dct_pkg::*;
#(
  parameter int FRAC = COS_FRAC
) (
  input  logic [LOG2N-1:0] k1,
  input  logic [LOG2N-1:0] k2,
  input  logic [LOG2N-1:0] n1,
  input  logic [LOG2N-1:0] n2,
  output cos_t             term
);

  localparam int SHIFT = COS_Q + 1 - FRAC;

  logic [PHASE_W-1:0] ph1, ph2, psum, pdiff;
  cos_t               pair_sum, mag, mag_shift;

  // cos(a)cos(b) = (cos(a+b) + cos(a-b)) / 2 turns the product into a sum of
  // two table lookups. Phases are multiples of pi/16, so modulo-32 arithmetic
  // on the phase words is exact. The pair sum is in Q20, so multiplying by
  // 2^FRAC/2 is a right shift; truncation toward zero is done on the
  // magnitude.
  always_comb begin
    ph1       = {1'b0, n1, 1'b1} * {2'b00, k1};
    ph2       = {1'b0, n2, 1'b1} * {2'b00, k2};
    psum      = ph1 + ph2;
    pdiff     = ph1 - ph2;
    pair_sum  = cos_q(psum) + cos_q(pdiff);
    mag       = pair_sum[31] ? -pair_sum : pair_sum;
    mag_shift = mag >> SHIFT;
    term      = pair_sum[31] ? -mag_shift : mag_shift;
  end

endmodule

// File: rtl/dct_coef_accum.sv
// dct_coef_accum: streams one NxN pixel block in raster order and produces a
// single 2-D DCT coefficient for the (k1,k2) latched at start.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset.
//   start               begin a block (sampled only in IDLE).
//   cfg_k1, cfg_k2      frequency pair, latched on start.
//   in_valid/in_ready   pixel handshake; in_data is a signed pixel.
//   out_valid/out_ready coefficient handshake; out_coef is signed.
//   out_sat             coefficient was clamped (DCT_SAT_EN builds only).
//   busy                high in ACCUM and DONE.
//
// Build macro: DCT_SAT_EN clamps out_coef to the signed OUT_W range and flags
// out_sat; without it out_coef is the low OUT_W bits and out_sat is 0.
// The cosine table in dct_pkg is built for N = 8.
module dct_coef_accum
  import dct_pkg::*;
#(
  parameter int N        = 8,
  parameter int LOG2N    = $clog2(N),
  parameter int DATA_W   = 9,
  parameter int COS_FRAC = 8,
  parameter int ACC_W    = 32,
  parameter int OUT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LOG2N-1:0]  cfg_k1,
  input  logic [LOG2N-1:0]  cfg_k2,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_coef,
  output logic              out_sat,
  output logic              busy
);

  localparam int IDX_W = 2 * LOG2N;

  state_t                   state, next_state;
  logic [LOG2N-1:0]         k1_reg, k2_reg;
  logic [IDX_W-1:0]         idx;
  logic signed [ACC_W-1:0]  acc, product;
  cos_t                     term;
  logic                     accept, last_pixel;

  assign accept     = in_valid && in_ready;
  assign last_pixel = (idx == IDX_W'(N*N - 1));

  dct_cos_term #(.FRAC(COS_FRAC)) u_cos_term (
    .k1   (k1_reg),
    .k2   (k2_reg),
    .n1   (idx[IDX_W-1:LOG2N]),
    .n2   (idx[LOG2N-1:0]),
    .term (term)
  );

  assign product = ACC_W'($signed(in_data)) * ACC_W'(term);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // in_ready is a pure state decode, so after the last handshake moves the
  // FSM to DONE no further pixel can be taken.
  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        if (start) next_state = ACCUM;
      end
      ACCUM: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid && last_pixel) next_state = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        if (out_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // The accumulator is left alone in DONE so the result stays stable until
  // the downstream handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc    <= '0;
      idx    <= '0;
      k1_reg <= '0;
      k2_reg <= '0;
    end else if (state == IDLE && start) begin
      acc    <= '0;
      idx    <= '0;
      k1_reg <= cfg_k1;
      k2_reg <= cfg_k2;
    end else if (accept) begin
      acc <= acc + product;
      idx <= idx + IDX_W'(1);
    end
  end

`ifdef DCT_SAT_EN
  localparam logic signed [ACC_W-1:0] COEF_MAX = ACC_W'((64'sd1 <<< (OUT_W-1)) - 64'sd1);
  localparam logic signed [ACC_W-1:0] COEF_MIN = ~COEF_MAX;

  logic signed [ACC_W-1:0] scaled;
  assign scaled = acc >>> COS_FRAC;
`endif

  // Bits [COS_FRAC +: OUT_W] of the accumulator are the floor-shifted result
  // reduced to OUT_W bits.
  always_comb begin
    out_coef = '0;
    out_sat  = 1'b0;
    if (state == DONE) begin
`ifdef DCT_SAT_EN
      if (scaled > COEF_MAX) begin
        out_coef = COEF_MAX[OUT_W-1:0];
        out_sat  = 1'b1;
      end else if (scaled < COEF_MIN) begin
        out_coef = COEF_MIN[OUT_W-1:0];
        out_sat  = 1'b1;
      end else begin
        out_coef = scaled[OUT_W-1:0];
      end
`else
      out_coef = acc[COS_FRAC +: OUT_W];
`endif
    end
  end

endmodule

// File: tb/tb_dct_coef_accum.sv
// tb_dct_coef_accum: directed bench for dct_coef_accum built with OUT_W = 12.
// Expected coefficients come from hand-computed constants and from a
// real-arithmetic cosine model. Honours DCT_SAT_EN for the saturation case.
module tb_dct_coef_accum;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  cfg_k1, cfg_k2;
  logic        in_valid;
  logic        in_ready;
  logic [8:0]  in_data;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_coef;
  logic        out_sat;
  logic        busy;

  int vectors     = 0;
  int miscompares = 0;
  int pix[64];

  localparam real PI = 3.14159265358979323846;

  dct_coef_accum #(.OUT_W(12)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .cfg_k1    (cfg_k1),
    .cfg_k2    (cfg_k2),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_coef  (out_coef),
    .out_sat   (out_sat),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #10000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic signed [31:0] observed,
                             input logic signed [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Small offset keeps products that are exactly integral in real arithmetic
  // (e.g. 0.5 * 256) from truncating one below because of double rounding.
  function automatic int cosRef(input int k1, input int k2, input int n1, input int n2);
    real v;
    v = 256.0 * $cos(real'((2*n1+1)*k1) * PI / 16.0) * $cos(real'((2*n2+1)*k2) * PI / 16.0);
    if (v >= 0.0) return $rtoi(v + 1.0e-6);
    else          return -$rtoi(-v + 1.0e-6);
  endfunction

  function automatic longint rawRef(input int k1, input int k2);
    longint sum;
    sum = 0;
    for (int i = 0; i < 64; i++) sum += longint'(pix[i]) * longint'(cosRef(k1, k2, i/8, i%8));
    return sum >>> 8;
  endfunction

  function automatic int refCoef(input int k1, input int k2);
    longint sh;
    logic signed [11:0] w;
    sh = rawRef(k1, k2);
`ifdef DCT_SAT_EN
    if (sh > 2047)  return 2047;
    if (sh < -2048) return -2048;
`endif
    w = sh[11:0];
    return int'(w);
  endfunction

  function automatic int refSat(input int k1, input int k2);
`ifdef DCT_SAT_EN
    longint sh;
    sh = rawRef(k1, k2);
    return (sh > 2047 || sh < -2048) ? 1 : 0;
`else
    return (k1 < 0 && k2 < 0) ? 1 : 0;
`endif
  endfunction

  // Starts a block and feeds pix[] until stop_after pixels were accepted.
  // Returns at the falling edge following the last accepting rising edge.
  task automatic applyStimulus(input int k1, input int k2, input bit gaps, input int stop_after);
    int accepted = 0;
    int cycles   = 0;
    bit take;
    @(negedge clk);
    cfg_k1 = 3'(k1);
    cfg_k2 = 3'(k2);
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (accepted < stop_after && cycles < 1000) begin
      in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      in_data  = 9'(pix[accepted]);
      if (gaps) begin
        start  = 1'($urandom_range(0, 1));
        cfg_k1 = 3'($urandom_range(0, 7));
        cfg_k2 = 3'($urandom_range(0, 7));
      end
      take = in_valid && in_ready;
      @(posedge clk);
      if (take) accepted++;
      cycles++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_data  = '0;
    start    = 1'b0;
    checkOutput("accept_count", accepted, stop_after);
  endtask

  task automatic collectOutput(input string tag, input int exp_coef, input int exp_sat,
                               input int hold, input bit poke_start);
    checkOutput({tag, "_valid"}, out_valid, 1);
    checkOutput({tag, "_inrdy"}, in_ready, 0);
    checkOutput({tag, "_coef"}, $signed(out_coef), exp_coef);
    checkOutput({tag, "_sat"}, out_sat, exp_sat);
    for (int c = 0; c < hold; c++) begin
      out_ready = 1'b0;
      start     = poke_start;
      @(negedge clk);
      checkOutput({tag, "_hold_coef"}, $signed(out_coef), exp_coef);
      checkOutput({tag, "_hold_valid"}, out_valid, 1);
      checkOutput({tag, "_hold_inrdy"}, in_ready, 0);
    end
    out_ready = 1'b1;
    start     = poke_start;
    @(negedge clk);
    out_ready = 1'b0;
    start     = 1'b0;
    checkOutput({tag, "_release"}, out_valid, 0);
    checkOutput({tag, "_idle"}, busy, 0);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_inrdy"}, in_ready, 0);
    checkOutput({tag, "_valid"}, out_valid, 0);
    checkOutput({tag, "_coef"}, $signed(out_coef), 0);
    checkOutput({tag, "_sat"}, out_sat, 0);
    checkOutput({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    int pos;
    rst       = 1'b1;
    start     = 1'b0;
    cfg_k1    = '0;
    cfg_k2    = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    checkAllZero("reset");
    rst = 1'b0;

    $display("[TB] DC block");
    for (int i = 0; i < 64; i++) pix[i] = 1;
    applyStimulus(0, 0, 1'b0, 64);
    collectOutput("dc", 64, 0, 0, 1'b0);

    $display("[TB] impulses at k=(7,7)");
    for (int i = 0; i < 64; i++) pix[i] = 0;
    pix[0] = 100;
    applyStimulus(7, 7, 1'b0, 64);
    collectOutput("imp00", 3, 0, 0, 1'b0);
    pix[0] = 0;
    pix[1] = -100;
    applyStimulus(7, 7, 1'b0, 64);
    collectOutput("imp01", 10, 0, 0, 1'b0);

    $display("[TB] handshake stress");
    for (int i = 0; i < 64; i++) pix[i] = ((i * 13) % 29) - 14;
    applyStimulus(2, 6, 1'b1, 64);
    collectOutput("stress", refCoef(2, 6), 0, 5, 1'b1);
    @(negedge clk);
    checkOutput("stress_no_restart", busy, 0);

    $display("[TB] mid-block reset");
    for (int i = 0; i < 64; i++) pix[i] = ((i * 37) % 41) - 20;
    applyStimulus(1, 4, 1'b0, 30);
    rst = 1'b1;
    #1;
    checkAllZero("midrst");
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(3, 5, 1'b0, 64);
    collectOutput("after_rst", refCoef(3, 5), 0, 0, 1'b0);

    $display("[TB] saturation");
    for (int i = 0; i < 64; i++) pix[i] = 127;
    applyStimulus(0, 0, 1'b0, 64);
`ifdef DCT_SAT_EN
    collectOutput("sat", 2047, 1, 0, 1'b0);
`else
    collectOutput("sat", -64, 0, 0, 1'b0);
`endif
    checkOutput("sat_model", refSat(0, 0), (`ifdef DCT_SAT_EN 1 `else 0 `endif));

    $display("[TB] cosine table sweep");
    for (int k1 = 0; k1 < 8; k1++) begin
      for (int k2 = 0; k2 < 8; k2++) begin
        for (int p = 0; p < 2; p++) begin
          for (int i = 0; i < 64; i++) pix[i] = 0;
          pos = (p == 0) ? (k2 * 8 + k1) : (((k1 + 3) % 8) * 8 + ((k2 + 5) % 8));
          pix[pos] = -256;
          applyStimulus(k1, k2, 1'b0, 64);
          collectOutput("table", -cosRef(k1, k2, pos / 8, pos % 8), 0, 0, 1'b0);
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
